// File: rtl/pe_restoring_divider.sv
// Multi-cycle unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per cycle, valid/ready on both sides.
module pe_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               dbz
);

  localparam int CW = $clog2(2*WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_dsr;
  logic [2*WIDTH-1:0] r_dvd;
  logic [2*WIDTH-1:0] r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic               r_dbz;

  logic               w_accept;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_nb;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH+1:0]   w_carry;
  logic               w_noborrow;

  // Trial subtraction as shift + ~{0,divisor} + 1; carry out of the top bit means no borrow.
  // Bit WIDTH of the difference is never kept: when there is no borrow it is always zero.
  assign w_shift    = {r_rem, r_dvd[2*WIDTH-1]};
  assign w_nb       = ~{1'b0, r_dsr};
  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_rca
    if (i < WIDTH) begin : g_sum
      assign w_diff[i] = w_shift[i] ^ w_nb[i] ^ w_carry[i];
    end
    assign w_carry[i+1] = (w_shift[i] & w_nb[i]) | (w_carry[i] & (w_shift[i] ^ w_nb[i]));
  end

  assign w_noborrow = w_carry[WIDTH+1];
  assign w_accept   = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (divisor == '0) ? S_DONE : S_BUSY;
      S_BUSY: if (r_cnt == '0) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Datapath; result registers are left untouched in DONE and after the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_dsr <= '0;
      r_dvd <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= CW'(2*WIDTH-1);
      r_dsr <= divisor;
      r_dvd <= dividend;
      r_rem <= '0;
      r_quo <= (divisor == '0) ? '1 : '0;
      r_dbz <= (divisor == '0);
    end else if (r_state == S_BUSY) begin
      r_rem <= w_noborrow ? w_diff : w_shift[WIDTH-1:0];
      r_quo <= {r_quo[2*WIDTH-2:0], w_noborrow};
      r_dvd <= {r_dvd[2*WIDTH-2:0], 1'b0};
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign dbz       = r_dbz;

endmodule
